// File: rtl/synth_pkg.sv
// Shared constants for the synth voice path: envelope state encodings and default level width.
package synth_pkg;

    localparam int AMP_W_DEF = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: o_tick is high for one clock every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign o_tick = (count == LAST);

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope generator: gate-driven state machine, level updated on prescaler ticks.
module envelope_gen
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 50,
    parameter int AMP_W    = AMP_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gate,
    input  logic [AMP_W-1:0] i_attack_rate,
    input  logic [AMP_W-1:0] i_decay_rate,
    input  logic [AMP_W-1:0] i_sustain_level,
    input  logic [AMP_W-1:0] i_release_rate,
    output logic [AMP_W-1:0] o_amp,
    output logic [2:0]       o_state,
    output logic             o_active
);

    // Saturating add toward full scale using a one-bit-wider sum.
    function automatic logic [AMP_W-1:0] sat_add(input logic [AMP_W-1:0] a,
                                                 input logic [AMP_W-1:0] b);
        logic [AMP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[AMP_W] ? '1 : s[AMP_W-1:0];
    endfunction

    // Subtract with borrow detection, clamped at a floor.
    function automatic logic [AMP_W-1:0] sub_floor(input logic [AMP_W-1:0] a,
                                                   input logic [AMP_W-1:0] b,
                                                   input logic [AMP_W-1:0] floor);
        logic [AMP_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return (d[AMP_W] || (d[AMP_W-1:0] <= floor)) ? floor : d[AMP_W-1:0];
    endfunction

    logic             tick;
    logic             gate_p0;
    logic             rise, fall;
    logic [2:0]       state, state_nxt;
    logic [AMP_W-1:0] level, level_nxt;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick)
    );

    assign rise = i_gate & ~gate_p0;
    assign fall = ~i_gate & gate_p0;

    // Gate edges take priority: they move the state and leave the level untouched.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        case (state)
            ST_IDLE: begin
                if (rise) state_nxt = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (fall) begin
                    state_nxt = ST_RELEASE;
                end else if (tick) begin
                    level_nxt = (i_attack_rate == '0) ? '1 : sat_add(level, i_attack_rate);
                    if (level_nxt == '1) state_nxt = ST_DECAY;
                end
            end
            ST_DECAY: begin
                if (fall) begin
                    state_nxt = ST_RELEASE;
                end else if (tick) begin
                    level_nxt = (i_decay_rate == '0) ? i_sustain_level
                              : sub_floor(level, i_decay_rate, i_sustain_level);
                    if (level_nxt == i_sustain_level) state_nxt = ST_SUSTAIN;
                end
            end
            ST_SUSTAIN: begin
                if (fall) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (rise) begin
                    state_nxt = ST_ATTACK;
                end else if (tick) begin
                    level_nxt = (i_release_rate == '0) ? '0 : sub_floor(level, i_release_rate, '0);
                    if (level_nxt == '0) state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                level_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            level   <= '0;
            gate_p0 <= 1'b0;
        end else begin
            state   <= state_nxt;
            level   <= level_nxt;
            gate_p0 <= i_gate;
        end
    end

    assign o_amp    = level;
    assign o_state  = state;
    assign o_active = (state != ST_IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen with TICK_DIV=4 and hand-computed envelope levels.
module tb_envelope_gen;

    logic        clk;
    logic        rst;
    logic        gate;
    logic [15:0] attack, decay, sustain, release_r;
    logic [15:0] amp;
    logic [2:0]  state;
    logic        active;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int ph;

    envelope_gen #(.TICK_DIV(4), .AMP_W(16)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_gate          (gate),
        .i_attack_rate   (attack),
        .i_decay_rate    (decay),
        .i_sustain_level (sustain),
        .i_release_rate  (release_r),
        .o_amp           (amp),
        .o_state         (state),
        .o_active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side prescaler phase: the edge after ph==3 is a tick edge.
    always @(posedge clk) begin
        if (rst) ph <= 0;
        else     ph <= (ph == 3) ? 0 : ph + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_clk();
        @(posedge clk);
        #1;
    endtask

    // Advance through the next tick edge; results are visible on return.
    task automatic to_tick();
        int n;
        n = 0;
        while (ph != 3 && n < 8) begin
            do_clk();
            n++;
        end
        chk_cnt++;
        if (ph != 3) $display("FAIL to_tick: phase %0d never reached 3", ph);
        else pass_cnt++;
        do_clk();
    endtask

    task automatic test_reset();
        rst = 1'b1; gate = 1'b1;
        attack = 16'h4000; decay = 16'h1000; sustain = 16'h8000; release_r = 16'h3000;
        do_clk(); do_clk();
        chk_cnt++; if (amp !== 16'h0000) $display("FAIL rst_amp: got %h want 0000", amp); else pass_cnt++;
        chk_cnt++; if (state !== 3'd0) $display("FAIL rst_state: got %0d want 0", state); else pass_cnt++;
        chk_cnt++; if (active !== 1'b0) $display("FAIL rst_active: got %b want 0", active); else pass_cnt++;
        rst = 1'b0;
        do_clk();
        chk_cnt++; if (state !== 3'd1) $display("FAIL rst_rise_state: got %0d want 1", state); else pass_cnt++;
        chk_cnt++; if (amp !== 16'h0000) $display("FAIL rst_rise_amp: got %h want 0000", amp); else pass_cnt++;
        chk_cnt++; if (active !== 1'b1) $display("FAIL rst_rise_active: got %b want 1", active); else pass_cnt++;
    endtask

    task automatic test_attack();
        logic [15:0] exp_a [4];
        exp_a = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            to_tick();
            chk_cnt++;
            if (amp !== exp_a[i]) $display("FAIL attack_%0d: got %h want %h", i, amp, exp_a[i]);
            else pass_cnt++;
            if (i == 0) begin
                do_clk();
                chk_cnt++;
                if (amp !== 16'h4000) $display("FAIL attack_hold: got %h want 4000", amp);
                else pass_cnt++;
            end
        end
        chk_cnt++; if (state !== 3'd2) $display("FAIL attack_to_decay: got %0d want 2", state); else pass_cnt++;
    endtask

    task automatic test_decay();
        logic [15:0] e;
        for (int i = 1; i <= 7; i++) begin
            to_tick();
            e = 16'hFFFF - 16'(i * 16'h1000);
            chk_cnt++;
            if (amp !== e) $display("FAIL decay_%0d: got %h want %h", i, amp, e);
            else pass_cnt++;
        end
        chk_cnt++; if (state !== 3'd2) $display("FAIL decay_state: got %0d want 2", state); else pass_cnt++;
        to_tick();
        chk_cnt++; if (amp !== 16'h8000) $display("FAIL decay_floor: got %h want 8000", amp); else pass_cnt++;
        chk_cnt++; if (state !== 3'd3) $display("FAIL decay_to_sustain: got %0d want 3", state); else pass_cnt++;
        sustain = 16'h4000;
        to_tick(); to_tick();
        chk_cnt++; if (amp !== 16'h8000) $display("FAIL sustain_hold: got %h want 8000", amp); else pass_cnt++;
        chk_cnt++; if (state !== 3'd3) $display("FAIL sustain_state: got %0d want 3", state); else pass_cnt++;
        sustain = 16'h8000;
    endtask

    task automatic test_release();
        logic [15:0] exp_r [3];
        exp_r = '{16'h5000, 16'h2000, 16'h0000};
        gate = 1'b0;
        do_clk();
        chk_cnt++; if (state !== 3'd4) $display("FAIL rel_enter: got %0d want 4", state); else pass_cnt++;
        chk_cnt++; if (amp !== 16'h8000) $display("FAIL rel_enter_amp: got %h want 8000", amp); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            to_tick();
            chk_cnt++;
            if (amp !== exp_r[i]) $display("FAIL release_%0d: got %h want %h", i, amp, exp_r[i]);
            else pass_cnt++;
        end
        chk_cnt++; if (state !== 3'd0) $display("FAIL rel_idle: got %0d want 0", state); else pass_cnt++;
        chk_cnt++; if (active !== 1'b0) $display("FAIL rel_active: got %b want 0", active); else pass_cnt++;
    endtask

    task automatic test_retrigger();
        gate = 1'b1; attack = 16'h0000; decay = 16'h0000;
        do_clk();
        to_tick();
        chk_cnt++; if (amp !== 16'hFFFF) $display("FAIL zero_attack: got %h want FFFF", amp); else pass_cnt++;
        to_tick();
        chk_cnt++; if (amp !== 16'h8000) $display("FAIL zero_decay: got %h want 8000", amp); else pass_cnt++;
        chk_cnt++; if (state !== 3'd3) $display("FAIL zero_decay_state: got %0d want 3", state); else pass_cnt++;
        gate = 1'b0;
        do_clk();
        to_tick(); to_tick();
        chk_cnt++; if (amp !== 16'h2000) $display("FAIL retrig_pre: got %h want 2000", amp); else pass_cnt++;
        gate = 1'b1; attack = 16'h4000;
        do_clk();
        chk_cnt++; if (state !== 3'd1) $display("FAIL retrig_state: got %0d want 1", state); else pass_cnt++;
        chk_cnt++; if (amp !== 16'h2000) $display("FAIL retrig_keep: got %h want 2000", amp); else pass_cnt++;
        to_tick();
        chk_cnt++; if (amp !== 16'h6000) $display("FAIL retrig_attack: got %h want 6000", amp); else pass_cnt++;
    endtask

    task automatic test_fall_on_tick();
        int n;
        n = 0;
        while (ph != 3 && n < 8) begin
            do_clk();
            n++;
        end
        gate = 1'b0;
        do_clk();
        chk_cnt++; if (state !== 3'd4) $display("FAIL fall_tick_state: got %0d want 4", state); else pass_cnt++;
        chk_cnt++; if (amp !== 16'h6000) $display("FAIL fall_tick_amp: got %h want 6000", amp); else pass_cnt++;
        release_r = 16'h0000;
        to_tick();
        chk_cnt++; if (amp !== 16'h0000) $display("FAIL zero_release: got %h want 0000", amp); else pass_cnt++;
        chk_cnt++; if (state !== 3'd0) $display("FAIL zero_release_state: got %0d want 0", state); else pass_cnt++;
        attack = 16'h0000; gate = 1'b1;
        do_clk();
        to_tick();
        chk_cnt++; if (amp !== 16'hFFFF) $display("FAIL zero_attack2: got %h want FFFF", amp); else pass_cnt++;
        chk_cnt++; if (state !== 3'd2) $display("FAIL zero_attack2_state: got %0d want 2", state); else pass_cnt++;
    endtask

    task automatic test_reset_mid_note();
        rst = 1'b1;
        do_clk();
        chk_cnt++; if (amp !== 16'h0000) $display("FAIL mid_rst_amp: got %h want 0000", amp); else pass_cnt++;
        chk_cnt++; if (state !== 3'd0) $display("FAIL mid_rst_state: got %0d want 0", state); else pass_cnt++;
        rst = 1'b0; attack = 16'h4000;
        do_clk();
        chk_cnt++; if (state !== 3'd1) $display("FAIL mid_rst_rise: got %0d want 1", state); else pass_cnt++;
        to_tick();
        chk_cnt++; if (amp !== 16'h4000) $display("FAIL mid_rst_attack: got %h want 4000", amp); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_retrigger();
        test_fall_on_tick();
        test_reset_mid_note();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/envelope_gen.md
ENVELOPE_GEN -- requirements
Module: envelope_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50, meaning i_clk cycles per envelope update tick (5 MHz / 50 = 100 kHz).
REQ-002 SHALL have parameter AMP_W, default 16, meaning envelope level width.
REQ-003 SHALL have port i_clk  in  1  system clock (5 MHz domain, same as amp path).
REQ-004 SHALL have port i_rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port i_gate  in  1  note gate, 1 = key held.
REQ-006 SHALL have port i_attack_rate  in  16  level increment per tick in ATTACK.
REQ-007 SHALL have port i_decay_rate  in  16  level decrement per tick in DECAY.
REQ-008 SHALL have port i_sustain_level  in  16  DECAY floor / SUSTAIN hold level.
REQ-009 SHALL have port i_release_rate  in  16  level decrement per tick in RELEASE.
REQ-010 SHALL have port o_amp  out  16  registered envelope level, drives amp i_amp.
REQ-011 SHALL have port o_state  out  3  current state encoding.
REQ-012 SHALL have port o_active  out  1  high whenever state != IDLE.

Function
REQ-013 SHALL implement states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; encodings 5-7 SHALL go to IDLE with level 0 on the next clock.
REQ-014 SHALL detect gate rise as i_gate=1 with previous-cycle sampled gate=0, and gate fall as the inverse.
REQ-015 SHALL run a free-running prescaler 0..TICK_DIV-1 and assert an internal tick on the cycle the count equals TICK_DIV-1.
REQ-016 SHALL change level only on tick cycles; o_amp SHALL reflect the new level one clock after the tick cycle.
REQ-017 SHALL go IDLE/RELEASE -> ATTACK on gate rise at that clock edge; retrigger from RELEASE SHALL keep current level (no reset to 0).
REQ-018 SHALL in ATTACK, per tick, set level = min(level + attack_rate, 2^AMP_W-1) using AMP_W+1-bit sum; on reaching full scale go to DECAY.
REQ-019 SHALL in DECAY, per tick, set level = max(level - decay_rate, sustain_level); on reaching sustain go to SUSTAIN; if sustain_level >= level on entry, go to SUSTAIN on the next tick with level = sustain_level.
REQ-020 SHALL in SUSTAIN hold level unchanged; i_sustain_level changes ignored until next DECAY.
REQ-021 SHALL in RELEASE, per tick, set level = max(level - release_rate, 0) with borrow detection; on reaching 0 go to IDLE.
REQ-022 SHALL go ATTACK/DECAY/SUSTAIN -> RELEASE on gate fall.
REQ-023 SHALL treat a rate of 0 as instantaneous: the phase reaches its target on the next tick.
REQ-024 SHALL give gate-driven transitions priority over tick arithmetic: on a cycle with both, state changes and level is unchanged.
REQ-025 SHALL sample rate inputs live on each tick (no latching).

Reset
REQ-026 SHALL, while i_rst=1 at a clock edge, force state=IDLE, level=0, prescaler=0, sampled gate=0; o_amp=0, o_state=0, o_active=0.
REQ-027 SHALL, on reset asserted mid-note, abandon the note; a gate held high through reset release SHALL be seen as a rise on the first cycle out of reset.

Structure
REQ-028 SHALL take state encodings and AMP_W default from shared package synth_pkg.
REQ-029 SHALL place the prescaler in sub-module tick_gen (ports i_clk, i_rst, o_tick; parameter TICK_DIV).

Verification (TICK_DIV=4)
REQ-030 SHALL verify: reset with gate high -> o_amp=0, o_state=0, o_active=0; release reset -> ATTACK next edge.
REQ-031 SHALL verify: attack=16'h4000, gate held -> o_amp 4000,8000,C000,FFFF on successive ticks, then o_state=DECAY.
REQ-032 SHALL verify: decay=16'h1000, sustain=16'h8000 from FFFF -> EFFF..8FFF then 8000 on 8th tick, o_state=SUSTAIN, holds 8000.
REQ-033 SHALL verify: gate fall in SUSTAIN, release=16'h3000 -> 5000,2000,0000, then IDLE, o_active=0.
REQ-034 SHALL verify: gate rise during RELEASE at level 2000 -> ATTACK, next tick 6000 with attack=16'h4000.
REQ-035 SHALL verify: gate fall on a tick cycle in ATTACK -> RELEASE, level unchanged that cycle; attack=0 -> FFFF on first tick.
